// File: rtl/reg_scoreboard_decoder.sv
// reg_scoreboard_decoder
//   Decodes the destination register of each issued instruction into a
//   one-hot write select and keeps a saturating count of outstanding
//   writes per register. Writebacks retire counts. The counts drive the
//   hazard (busy) flags for the two source operands.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset_n       asynchronous active-low reset
//   flush         synchronous clear of every pending count
//   issue_en      issue request for destination issue_rd
//   issue_rd      destination index of the issuing instruction
//   issue_ready   issue can be accepted this cycle (combinational)
//   issue_onehot  one-hot decode of issue_rd, gated by issue_en & issue_ready
//   wb_en/wb_rd   writeback valid / destination index
//   rs1, rs2      source operand indices
//   rs1_busy      rs1 has a pending write (combinational)
//   rs2_busy      rs2 has a pending write (combinational)
//   busy_vec      bit i set while register i has a pending write
//   wb_err        one-cycle pulse: writeback to a register with nothing pending
module reg_scoreboard_decoder #(
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 2,
    parameter int ZERO_REG  = 31,
    parameter int WB_BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_rd,
    output logic                   issue_ready,
    output logic [2**ADDR_W-1:0]   issue_onehot,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_rd,
    input  logic [ADDR_W-1:0]      rs1,
    input  logic [ADDR_W-1:0]      rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic                   wb_err
);

    localparam int                NREGS    = 2**ADDR_W;
    localparam logic [CNT_W-1:0]  MAXCNT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic             issue_fire;

    // A full counter can still accept an issue when a writeback to the same
    // register retires one entry in this cycle (unless flush discards it).
    assign issue_ready = (cnt[issue_rd] != MAXCNT)
                      || (wb_en && (wb_rd == issue_rd) && !flush)
                      || (issue_rd == ZERO_IDX);
    assign issue_fire  = issue_en && issue_ready;

    always_comb begin
        issue_onehot = '0;
        inc          = '0;
        dec          = '0;
        busy_vec     = '0;
        for (int i = 0; i < NREGS; i++) begin
            issue_onehot[i] = issue_fire && (issue_rd == ADDR_W'(i));
            inc[i]          = issue_onehot[i] && (ADDR_W'(i) != ZERO_IDX);
            dec[i]          = wb_en && (wb_rd == ADDR_W'(i)) && (cnt[i] != '0);
            busy_vec[i]     = (cnt[i] != '0);
        end
    end

    // A retiring writeback on the last pending entry hides the hazard in the
    // same cycle when bypass is enabled.
    assign rs1_busy = (cnt[rs1] != '0) && (rs1 != ZERO_IDX)
                   && !((WB_BYPASS != 0) && wb_en && (wb_rd == rs1) && (cnt[rs1] == ONE));
    assign rs2_busy = (cnt[rs2] != '0) && (rs2 != ZERO_IDX)
                   && !((WB_BYPASS != 0) && wb_en && (wb_rd == rs2) && (cnt[rs2] == ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else if (inc[i] && !dec[i] && (cnt[i] != MAXCNT)) begin
                    cnt[i] <= cnt[i] + ONE;
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - ONE;
                end
            end
            wb_err <= wb_en && (wb_rd != ZERO_IDX) && (cnt[wb_rd] == '0) && !flush;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
module tb_reg_scoreboard_decoder;

    localparam int NREGS = 32;
    localparam int MAXC  = 3;
    localparam int ZR    = 31;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic        ready, ready_nb;
    logic [31:0] onehot, onehot_nb;
    logic        rs1b, rs2b, rs1b_nb, rs2b_nb;
    logic [31:0] bvec, bvec_nb;
    logic        err, err_nb;

    int checks;
    int failures;

    // reference model: outstanding-write count per register
    int  m_cnt [NREGS];
    bit  m_err;

    reg_scoreboard_decoder #(.ADDR_W(5), .CNT_W(2), .ZERO_REG(31), .WB_BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(ready), .issue_onehot(onehot),
        .wb_en(wb_en), .wb_rd(wb_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1b), .rs2_busy(rs2b), .busy_vec(bvec), .wb_err(err)
    );

    reg_scoreboard_decoder #(.ADDR_W(5), .CNT_W(2), .ZERO_REG(31), .WB_BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(ready_nb), .issue_onehot(onehot_nb),
        .wb_en(wb_en), .wb_rd(wb_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1b_nb), .rs2_busy(rs2b_nb), .busy_vec(bvec_nb), .wb_err(err_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_ready();
        return (m_cnt[issue_rd] < MAXC) || (wb_en && wb_rd == issue_rd && !flush) || (int'(issue_rd) == ZR);
    endfunction

    function automatic logic [31:0] m_onehot();
        logic [31:0] v;
        v = '0;
        if (issue_en && m_ready()) v[issue_rd] = 1'b1;
        return v;
    endfunction

    function automatic bit m_busy(input int rs, input bit bypass);
        if (rs == ZR || m_cnt[rs] == 0) return 1'b0;
        if (bypass && wb_en && int'(wb_rd) == rs && m_cnt[rs] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_bvec();
        logic [31:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
        m_err = 1'b0;
    endtask

    // model the effect of one rising edge using the inputs present at it
    task automatic m_edge();
        bit add, sub;
        if (flush) begin
            m_clear();
        end else begin
            m_err = wb_en && int'(wb_rd) != ZR && m_cnt[wb_rd] == 0;
            add   = issue_en && m_ready() && int'(issue_rd) != ZR;
            sub   = wb_en && m_cnt[wb_rd] > 0;
            if (add && sub && issue_rd == wb_rd) begin
                // retire and reissue on the same register cancel
            end else begin
                if (add && m_cnt[issue_rd] < MAXC) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
                if (sub) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
            end
        end
    endtask

    task automatic apply(input bit e, input int r, input bit we, input int wr,
                         input bit f, input int a, input int b);
        @(negedge clk);
        issue_en = e;  issue_rd = 5'(r);
        wb_en    = we; wb_rd    = 5'(wr);
        flush    = f;  rs1      = 5'(a); rs2 = 5'(b);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        issue_en = 1'($urandom); issue_rd = 5'($urandom); wb_en = 1'($urandom);
        wb_rd    = 5'($urandom); flush = 1'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        m_clear();
        #12;
        checks++;
        if (bvec !== 32'h0 || err !== 1'b0 || rs1b !== 1'b0 || rs2b !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: bvec=%h err=%b rs1b=%b rs2b=%b, required 0/0/0/0", bvec, err, rs1b, rs2b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_issue_wb();
        apply(1, 5, 0, 0, 0, 5, 0);
        checks++;
        if (onehot !== 32'h0000_0020 || ready !== 1'b1 || rs1b !== 1'b0) begin
            failures++;
            $display("FAIL issue5_decode: onehot=%h ready=%b rs1b=%b, required 00000020/1/0", onehot, ready, rs1b);
        end
        tick();
        checks++;
        if (bvec !== 32'h0000_0020) begin
            failures++;
            $display("FAIL issue5_busy_vec: got %h, required 00000020", bvec);
        end
        apply(0, 0, 0, 0, 0, 5, 0);
        checks++;
        if (rs1b !== 1'b1) begin
            failures++;
            $display("FAIL issue5_rs1_busy: got %b, required 1", rs1b);
        end
        apply(0, 0, 1, 5, 0, 0, 0);
        tick();
        checks++;
        if (bvec !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL wb5_release: bvec=%h err=%b, required 0/0", bvec, err);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            apply(1, 7, 0, 0, 0, 0, 0);
            tick();
        end
        apply(1, 7, 0, 0, 0, 0, 0);
        checks++;
        if (ready !== 1'b0 || onehot !== 32'h0) begin
            failures++;
            $display("FAIL sat_full: ready=%b onehot=%h, required 0/00000000", ready, onehot);
        end
        tick();
        apply(1, 7, 1, 7, 0, 0, 0);
        checks++;
        if (ready !== 1'b1 || onehot !== 32'h0000_0080) begin
            failures++;
            $display("FAIL sat_wb_ready: ready=%b onehot=%h, required 1/00000080", ready, onehot);
        end
        tick();
        apply(1, 7, 0, 0, 0, 0, 0);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_still_full: ready=%b, required 0", ready);
        end
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 1, 7, 0, 0, 0);
            tick();
            checks++;
            if (bvec !== m_bvec() || err !== 1'b0) begin
                failures++;
                $display("FAIL sat_drain%0d: bvec=%h err=%b, required %h/0", k, bvec, err, m_bvec());
            end
        end
        checks++;
        if (bvec[7] !== 1'b0) begin
            failures++;
            $display("FAIL sat_drained: bvec[7]=%b, required 0", bvec[7]);
        end
    endtask

    task automatic test_bypass();
        apply(1, 9, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 1, 9, 0, 0, 9);
        checks++;
        if (rs2b !== 1'b0 || rs2b_nb !== 1'b1) begin
            failures++;
            $display("FAIL bypass_rs2: bypass=%b nobypass=%b, required 0/1", rs2b, rs2b_nb);
        end
        tick();
    endtask

    task automatic test_err_zero();
        apply(0, 0, 1, 12, 0, 0, 0);
        tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL wb_err_pulse: got %b, required 1", err);
        end
        apply(0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL wb_err_clear: got %b, required 0", err);
        end
        for (int k = 0; k < 5; k++) begin
            apply(1, 31, 0, 0, 0, 31, 31);
            checks++;
            if (ready !== 1'b1 || onehot !== 32'h8000_0000) begin
                failures++;
                $display("FAIL zero_issue%0d: ready=%b onehot=%h, required 1/80000000", k, ready, onehot);
            end
            tick();
        end
        apply(0, 0, 1, 31, 0, 31, 31);
        checks++;
        if (rs1b !== 1'b0 || rs2b_nb !== 1'b0 || bvec !== 32'h0) begin
            failures++;
            $display("FAIL zero_busy: rs1b=%b rs2b_nb=%b bvec=%h, required 0/0/0", rs1b, rs2b_nb, bvec);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL zero_wb_err: got %b, required 0", err);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            apply(1, r, 0, 0, 0, 0, 0);
            tick();
        end
        checks++;
        if (bvec !== 32'h0000_000E) begin
            failures++;
            $display("FAIL flush_pre: bvec=%h, required 0000000e", bvec);
        end
        apply(1, 4, 1, 12, 1, 0, 0);
        checks++;
        if (ready !== 1'b1 || onehot !== 32'h0000_0010) begin
            failures++;
            $display("FAIL flush_comb: ready=%b onehot=%h, required 1/00000010", ready, onehot);
        end
        tick();
        checks++;
        if (bvec !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: bvec=%h err=%b, required 0/0", bvec, err);
        end
        for (int i = 0; i < NREGS; i++) begin
            logic [31:0] exp_oh;
            exp_oh = 32'h1 << i;
            apply(1, i, 0, 0, 1, 0, 0);
            checks++;
            if (onehot !== exp_oh) begin
                failures++;
                $display("FAIL decode_sweep%0d: onehot=%h, required %h", i, onehot, exp_oh);
            end
            apply(0, i, 0, 0, 1, 0, 0);
            checks++;
            if (onehot !== 32'h0) begin
                failures++;
                $display("FAIL decode_gate%0d: onehot=%h, required 00000000", i, onehot);
            end
        end
        tick();
        m_clear();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int  r, wr, a, b;
            bit  e, we, f;
            logic [31:0] exp_oh;
            r  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 5));
            wr = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 5));
            a  = int'($urandom_range(0, 6));
            b  = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 6));
            e  = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 2) == 0);
            f  = ($urandom_range(0, 40) == 0);
            apply(e, r, we, wr, f, a, b);
            exp_oh = m_onehot();
            checks++;
            if (ready !== m_ready() || onehot !== exp_oh) begin
                failures++;
                $display("FAIL rand_issue%0d: ready=%b onehot=%h, required %b/%h", n, ready, onehot, m_ready(), exp_oh);
            end
            checks++;
            if (rs1b !== m_busy(a, 1) || rs2b !== m_busy(b, 1)
                || rs1b_nb !== m_busy(a, 0) || rs2b_nb !== m_busy(b, 0)) begin
                failures++;
                $display("FAIL rand_busy%0d: %b%b%b%b, required %b%b%b%b", n, rs1b, rs2b, rs1b_nb, rs2b_nb,
                         m_busy(a, 1), m_busy(b, 1), m_busy(a, 0), m_busy(b, 0));
            end
            tick();
            checks++;
            if (bvec !== m_bvec() || err !== m_err) begin
                failures++;
                $display("FAIL rand_state%0d: bvec=%h err=%b, required %h/%b", n, bvec, err, m_bvec(), m_err);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(1, 6, 0, 0, 0, 6, 0);
        tick();
        apply(0, 0, 1, 3, 0, 6, 0);
        #1;
        reset_n = 1'b0;
        #1;
        m_clear();
        checks++;
        if (bvec !== 32'h0 || err !== 1'b0 || rs1b !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: bvec=%h err=%b rs1b=%b, required 0/0/0", bvec, err, rs1b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        apply(1, 5, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bvec !== 32'h0000_0020 || err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: bvec=%h err=%b, required 00000020/0", bvec, err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_issue_wb();
        test_saturation();
        test_bypass();
        test_err_zero();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
